alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU (32-bit operands, 4-bit alucontrol, 32-bit result, 4-bit flags {v,c,n,z}) between NUM_REQ requesters, for example the core execute stage and an APB-side accelerator.
- Arbitration is round-robin.
- Each accepted request is presented to the ALU for one cycle, and the result and flags are captured into a registered response slot.
- The response slot is returned to the originating requester under a valid/ready handshake.
- Throughput is one operation per cycle when no requester stalls the response.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TAG_W, 4, width of the requester-supplied tag, returned unchanged in the response.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_a  in  NUM_REQ x 32  operand a per requester (packed array).
- req_b  in  NUM_REQ x 32  operand b per requester.
- req_op  in  NUM_REQ x 4  alucontrol encoding per requester.
- req_tag  in  NUM_REQ x TAG_W  opaque tag.
- rsp_valid  out  NUM_REQ  response valid, one-hot or zero.
- rsp_ready  in  NUM_REQ  requester accepts response.
- rsp_result  out  32  captured ALU result.
- rsp_flags  out  4  captured {v,c,n,z}.
- rsp_tag  out  TAG_W  tag of the captured request.
- rsp_err  out  1  op was illegal (greater than 4'b1000).
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_control  out  4  to ALU alucontrol.
- alu_result  in  32  from ALU.
- alu_flags  in  4  from ALU.

Behaviour:
- Reset (async, reset_n=0) sets the following, and the block leaves reset with the slot empty:
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_tag=0, rsp_err=0.
  - Round-robin pointer = 0; requester 0 has highest priority first.
- Response slot states:
  - EMPTY: no response held.
  - FULL(owner): response held for requester owner.
- can_accept = EMPTY, or (FULL and rsp_ready[owner]=1). Same-cycle drain and refill is required.
- Grant, when can_accept=1:
  - Select the first asserted req_valid, searching from pointer upward with wrap-around.
  - Assert req_ready for that requester only.
  - Drive alu_a/alu_b/alu_control combinationally from the winner.
  - On clk, capture alu_result, alu_flags, req_tag and owner into the slot.
  - Set the pointer to winner+1 mod NUM_REQ.
- No grant (can_accept=0 or no req_valid):
  - alu_* outputs are driven to 0 and alu_control=4'b0000.
  - The pointer is unchanged.
- Latency: a request accepted in cycle N gives rsp_valid[owner]=1 in cycle N+1.
- Hold rule: rsp_* is held stable while rsp_valid=1 and rsp_ready[owner]=0.
- rsp_ready bits of non-owners are ignored.
- Illegal op (req_op greater than 4'b1000):
  - The request is still accepted.
  - The slot captures result=0, flags=0, rsp_err=1; ALU outputs are ignored.
  - alu_control is forced to 4'b0000 that cycle.
- Flags are captured for every legal op. The ALU masks v and c for non-add/sub ops, and the arbiter does not alter them.
- Requesters must hold req_* stable until req_ready. The arbiter never drops an accepted request.
- Reset mid-operation discards any held response. No response is issued for it afterward.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock[NUM_REQ].
  - If the current winner has req_lock=1 at grant, the pointer stays on that winner. It keeps highest priority for back-to-back sequences, e.g. multi-word add/compare.
  - The lock releases on the first grant with req_lock=0, or when that requester deasserts req_valid.
- When undefined: no port is added and rotation is plain round-robin.

Decomposition:
- Package alu_pkg holds:
  - typedef alu_op_t (4-bit enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7, SRA=8).
  - Constant ALU_OP_MAX=4'h8.
  - Flag bit indices FLAG_V=3, FLAG_C=2, FLAG_N=1, FLAG_Z=0.
- One sub-module, rr_arbiter: parameterised NUM_REQ, inputs req and pointer, outputs grant one-hot. Lock handling and the response slot stay in alu_arbiter.

Test Plan:
- Single request: req0 ADD a=5 b=7 -> req_ready[0] the same cycle; next cycle rsp_valid[0]=1, result=12, flags=4'b0000.
- Contention: req0 and req1 valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1; one response per cycle; tags match owners.
- Backpressure: rsp_ready[0]=0 for 3 cycles after a SUB a=3 b=3 -> result=0, flags z=1 held stable; no req_ready during stall; grant resumes on the drain cycle.
- Illegal op: req1 op=4'hF -> rsp_err=1, result=0, flags=0, alu_control=0 in the grant cycle.
- Overflow flag: ADD a=32'h7FFFFFFF b=1 -> result=32'h80000000, flags v=1, n=1.
- Reset during FULL slot: assert reset_n=0 with rsp_valid=1 -> rsp_valid=0 immediately (async); after release, req0 gets the first grant.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, flag bit positions and slot state.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLT = 4'h5,
    ALU_SLL = 4'h6,
    ALU_SRL = 4'h7,
    ALU_SRA = 4'h8
  } alu_op_t;

  localparam logic [3:0] ALU_OP_MAX = 4'h8;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin grant: first asserted request at or above ptr, with wrap-around.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    // Outer loop walks priority ranks; inner loop finds the requester at that rank.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == (int'(ptr) + k) % NUM_REQ)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with a registered response slot.
// Optional ALU_ARB_LOCK_EN adds req_lock to keep priority on a winner across back-to-back ops.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][31:0]        req_a,
  input  logic [NUM_REQ-1:0][31:0]        req_b,
  input  logic [NUM_REQ-1:0][3:0]         req_op,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]              req_lock,
`endif
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [31:0]                     rsp_result,
  output logic [3:0]                      rsp_flags,
  output logic [TAG_W-1:0]                rsp_tag,
  output logic                            rsp_err,
  output logic [31:0]                     alu_a,
  output logic [31:0]                     alu_b,
  output logic [3:0]                      alu_control,
  input  logic [31:0]                     alu_result,
  input  logic [3:0]                      alu_flags
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  slot_state_t        state_q, state_d;
  logic [PTR_W-1:0]   owner_q;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   winner;
  logic               can_accept;
  logic               any_grant;
  logic               illegal;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // A full slot may be drained and refilled in the same cycle.
  assign can_accept = (state_q == SLOT_EMPTY) || rsp_ready[owner_q];
  assign req_ready  = can_accept ? grant : '0;
  assign any_grant  = |req_ready;

  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) winner = PTR_W'(i);
    end
  end

  assign illegal     = is_illegal_op(req_op[winner]);
  assign alu_a       = any_grant ? req_a[winner] : '0;
  assign alu_b       = any_grant ? req_b[winner] : '0;
  assign alu_control = (any_grant && !illegal) ? req_op[winner] : 4'b0000;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (any_grant) begin
      state_d = SLOT_FULL;
      ptr_d   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
`ifdef ALU_ARB_LOCK_EN
      // Locked winner keeps top priority; a grant without lock, or the winner
      // dropping req_valid, lets the search move on naturally.
      if (req_lock[winner]) ptr_d = winner;
`endif
    end else if ((state_q == SLOT_FULL) && rsp_ready[owner_q]) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == SLOT_FULL) rsp_valid[owner_q] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SLOT_EMPTY;
      owner_q    <= '0;
      ptr_q      <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (any_grant) begin
        owner_q    <= winner;
        rsp_tag    <= req_tag[winner];
        rsp_err    <= illegal;
        rsp_result <= illegal ? 32'd0 : alu_result;
        rsp_flags  <= illegal ? 4'd0 : alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 4;

  logic                          clk = 1'b0;
  logic                          reset_n;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][31:0]      req_a;
  logic [NUM_REQ-1:0][31:0]      req_b;
  logic [NUM_REQ-1:0][3:0]       req_op;
  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
`ifdef ALU_ARB_LOCK_EN
  logic [NUM_REQ-1:0]            req_lock = '0;
`endif
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [31:0]                   rsp_result;
  logic [3:0]                    rsp_flags;
  logic [TAG_W-1:0]              rsp_tag;
  logic                          rsp_err;
  logic [31:0]                   alu_a;
  logic [31:0]                   alu_b;
  logic [3:0]                    alu_control;
  logic [31:0]                   alu_result;
  logic [3:0]                    alu_flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .req_tag     (req_tag),
`ifdef ALU_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_tag     (rsp_tag),
    .rsp_err     (rsp_err),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags)
  );

  // Reference ALU: v/c only for add/sub, carry on sub is the no-borrow carry-out.
  logic [32:0] sum33;
  logic        fv, fc;
  always_comb begin
    sum33      = '0;
    fv         = 1'b0;
    fc         = 1'b0;
    alu_result = '0;
    case (alu_control)
      ALU_ADD: begin
        sum33      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum33[31:0];
        fc         = sum33[32];
        fv         = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      ALU_SUB: begin
        sum33      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = sum33[31:0];
        fc         = sum33[32];
        fv         = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLL: alu_result = alu_a << alu_b[4:0];
      ALU_SRL: alu_result = alu_a >> alu_b[4:0];
      ALU_SRA: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = '0;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_V] = fv;
    alu_flags[FLAG_C] = fc;
    alu_flags[FLAG_N] = alu_result[31];
    alu_flags[FLAG_Z] = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
    req_op[idx]  = op;
    req_a[idx]   = a;
    req_b[idx]   = b;
    req_tag[idx] = tag;
  endtask

  logic [1:0]  exp_grant;
  logic [31:0] exp_res;
  logic [3:0]  exp_flags;
  logic [3:0]  exp_tag;

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    req_tag   = '0;
    rsp_ready = 2'b11;

    // Reset state
    #2;
    check("reset_req_ready",  req_ready,  2'b00);
    check("reset_rsp_valid",  rsp_valid,  2'b00);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_rsp_flags",  rsp_flags,  4'd0);
    check("reset_rsp_tag",    rsp_tag,    4'd0);
    check("reset_rsp_err",    rsp_err,    1'b0);
    step();
    reset_n = 1'b1;
    step();

    // Single request: ADD 5+7 from requester 0
    set_req(0, ALU_ADD, 32'd5, 32'd7, 4'd3);
    req_valid = 2'b01;
    #1;
    check("single_req_ready", req_ready, 2'b01);
    check("single_alu_a",     alu_a,     32'd5);
    check("single_alu_b",     alu_b,     32'd7);
    check("single_rsp_empty", rsp_valid, 2'b00);
    step();
    check("single_rsp_valid", rsp_valid,  2'b01);
    check("single_result",    rsp_result, 32'd12);
    check("single_flags",     rsp_flags,  4'b0000);
    check("single_tag",       rsp_tag,    4'd3);
    check("single_err",       rsp_err,    1'b0);
    req_valid = 2'b00;
    step();
    check("single_drained", rsp_valid, 2'b00);

    // Contention: pointer now at 1, so grants go 1,0,1,0
    set_req(0, ALU_ADD, 32'd1,  32'd1, 4'd1);
    set_req(1, ALU_SUB, 32'd10, 32'd4, 4'd2);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_grant = (k % 2 == 0) ? 2'b10 : 2'b01;
      exp_res   = (k % 2 == 0) ? 32'd6 : 32'd2;
      exp_flags = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      exp_tag   = (k % 2 == 0) ? 4'd2 : 4'd1;
      #1;
      check($sformatf("cont_grant_%0d", k), req_ready, exp_grant);
      step();
      check($sformatf("cont_rsp_valid_%0d", k), rsp_valid,  exp_grant);
      check($sformatf("cont_result_%0d", k),    rsp_result, exp_res);
      check($sformatf("cont_flags_%0d", k),     rsp_flags,  exp_flags);
      check($sformatf("cont_tag_%0d", k),       rsp_tag,    exp_tag);
    end
    req_valid = 2'b00;
    step();
    check("cont_drained", rsp_valid, 2'b00);

    // Backpressure: owner 0 stalls three cycles; requester 1's ready bit must be ignored
    rsp_ready = 2'b10;
    set_req(0, ALU_SUB, 32'd3, 32'd3, 4'd4);
    req_valid = 2'b01;
    #1;
    check("bp_grant", req_ready, 2'b01);
    step();
    check("bp_rsp_valid", rsp_valid,  2'b01);
    check("bp_result",    rsp_result, 32'd0);
    check("bp_flags",     rsp_flags,  4'b0101);
    set_req(0, ALU_ADD, 32'd5, 32'd7, 4'd9);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_stall_ready_%0d", k), req_ready,  2'b00);
      check($sformatf("bp_stall_alu_a_%0d", k), alu_a,      32'd0);
      check($sformatf("bp_hold_valid_%0d", k),  rsp_valid,  2'b01);
      check($sformatf("bp_hold_flags_%0d", k),  rsp_flags,  4'b0101);
      check($sformatf("bp_hold_tag_%0d", k),    rsp_tag,    4'd4);
      step();
    end
    rsp_ready = 2'b11;
    #1;
    check("bp_drain_refill_grant", req_ready, 2'b01);
    step();
    check("bp_refill_valid",  rsp_valid,  2'b01);
    check("bp_refill_result", rsp_result, 32'd12);
    check("bp_refill_tag",    rsp_tag,    4'd9);
    req_valid = 2'b00;
    step();

    // Illegal op from requester 1: ALU control forced to 0, response zeroed with err
    set_req(1, 4'hF, 32'd1, 32'd2, 4'd5);
    req_valid = 2'b10;
    #1;
    check("ill_grant",       req_ready,   2'b10);
    check("ill_alu_control", alu_control, 4'b0000);
    step();
    check("ill_rsp_valid", rsp_valid,  2'b10);
    check("ill_result",    rsp_result, 32'd0);
    check("ill_flags",     rsp_flags,  4'd0);
    check("ill_err",       rsp_err,    1'b1);
    check("ill_tag",       rsp_tag,    4'd5);
    req_valid = 2'b00;
    step();

    // Signed overflow on ADD; hold the slot full for the reset test
    rsp_ready = 2'b00;
    set_req(0, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 4'd6);
    req_valid = 2'b01;
    #1;
    check("ovf_grant", req_ready, 2'b01);
    step();
    check("ovf_result", rsp_result, 32'h8000_0000);
    check("ovf_flags",  rsp_flags,  4'b1010);
    check("ovf_err",    rsp_err,    1'b0);
    req_valid = 2'b00;
    step();
    check("ovf_held_valid", rsp_valid, 2'b01);

    // Asynchronous reset with a full slot, then requester 0 wins first
    reset_n = 1'b0;
    #1;
    check("rst_async_valid",  rsp_valid,  2'b00);
    check("rst_async_result", rsp_result, 32'd0);
    check("rst_async_tag",    rsp_tag,    4'd0);
    step();
    reset_n   = 1'b1;
    rsp_ready = 2'b11;
    set_req(0, ALU_ADD, 32'd0, 32'd0, 4'd8);
    set_req(1, ALU_ADD, 32'd2, 32'd3, 4'd7);
    req_valid = 2'b11;
    #1;
    check("rst_no_stale_rsp", rsp_valid, 2'b00);
    check("rst_first_grant",  req_ready, 2'b01);
    step();
    check("rst_rsp_valid", rsp_valid, 2'b01);
    check("rst_rsp_tag",   rsp_tag,   4'd8);
    check("rst_rsp_flags", rsp_flags, 4'b0001);
    req_valid = 2'b00;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
